// File: rtl/planar_frame_writer_pkg.sv
// Shared types for the planar frame writer and the display fetch path.
package planar_frame_writer_pkg;

    localparam logic [3:0] DDR_CORE_BASE = 4'b0011;

    typedef struct packed {
        logic [28:0] y_adr;
        logic [28:0] u_adr;
        logic [28:0] v_adr;
    } planar_yuv_s;

    typedef enum logic [1:0] {
        PLANE_Y = 2'd0,
        PLANE_U = 2'd1,
        PLANE_V = 2'd2
    } yuv_plane_e;

    typedef enum logic [1:0] {StIdle, StFill, StFlush, StBurst} wr_state_e;

    // Chroma rows are half the luma width in 4:2:0.
    function automatic logic [8:0] row_len(input logic [8:0] width, input yuv_plane_e plane);
        return (plane == PLANE_Y) ? width : {1'b0, width[8:1]};
    endfunction

endpackage

// File: rtl/planar_frame_writer_if.sv
// DDR arbiter port: burst write master (to_host) and arbiter side (to_arb).
interface ddr_if;
    logic [28:0] addr;
    logic        write;
    logic        read;
    logic [63:0] wdata;
    logic [7:0]  byteenable;
    logic [7:0]  burstcnt;
    logic        acquire;
    logic        busy;

    modport to_host (
        output addr, write, read, wdata, byteenable, burstcnt, acquire,
        input  busy
    );

    modport to_arb (
        input  addr, write, read, wdata, byteenable, burstcnt, acquire,
        output busy
    );
endinterface

// File: rtl/planar_frame_writer_row_buffer.sv
// Row buffer: simple dual-port Words x 64 RAM, registered read, single clock.
module ddr_row_buffer #(
    parameter int unsigned Words = 64,
    parameter int unsigned Aw    = 6
) (
    input  logic          clkddr,
    input  logic          reset,
    input  logic          we_i,
    input  logic [Aw-1:0] waddr_i,
    input  logic [63:0]   wdata_i,
    input  logic          re_i,
    input  logic [Aw-1:0] raddr_i,
    output logic [63:0]   rdata_o
);
    logic [63:0] mem_q [Words];
    logic [63:0] rdata_q;

    always_ff @(posedge clkddr) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    always_ff @(posedge clkddr) begin
        if (reset)     rdata_q <= '0;
        else if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/planar_frame_writer.sv
// Packs decoded YUV 4:2:0 rows into 64-bit words and burst-writes them to DDR per plane.
// Define FRAME_WRITER_CHECKSUM_EN to build the running byte checksum.
module planar_frame_writer
    import planar_frame_writer_pkg::*;
#(
    parameter int unsigned LINE_WORDS = 64
) (
    input  logic         clkddr,
    input  logic         reset,
    ddr_if.to_host       ddrif,
    input  planar_yuv_s  frame,
    input  logic [8:0]   frame_width,
    input  logic [8:0]   frame_height,
    input  logic         start,
    input  logic [7:0]   in_data,
    input  logic [1:0]   in_plane,
    input  logic         in_valid,
    output logic         in_ready,
    output logic         busy,
    output logic         done,
    output logic [31:0]  checksum
);
    localparam int unsigned Aw = $clog2(LINE_WORDS);

    wr_state_e   state_q, state_d;
    logic [28:0] adr_y_q, adr_y_d, adr_u_q, adr_u_d, adr_v_q, adr_v_d;
    logic [8:0]  rows_y_q, rows_y_d, rows_u_q, rows_u_d, rows_v_q, rows_v_d;
    logic [8:0]  width_q, width_d, byte_cnt_q, byte_cnt_d;
    yuv_plane_e  plane_q, plane_d, cur_plane;
    logic [63:0] pack_q, pack_d, rdata;
    logic [5:0]  beat_q, beat_d, burst_len;
    logic        err_q, err_d, done_q, done_d;
    logic [28:0] cur_adr;
    logic [8:0]  cur_rows, cur_len;
    logic        keep_byte, buf_we, buf_re;
    logic [Aw-1:0] buf_raddr;

    // The plane of a row is taken from the first byte; afterwards it is held in plane_q.
    always_comb begin
        cur_plane = (state_q == StFill && byte_cnt_q == '0) ? yuv_plane_e'(in_plane) : plane_q;
        case (cur_plane)
            PLANE_Y: begin cur_adr = adr_y_q; cur_rows = rows_y_q; end
            PLANE_U: begin cur_adr = adr_u_q; cur_rows = rows_u_q; end
            PLANE_V: begin cur_adr = adr_v_q; cur_rows = rows_v_q; end
            default: begin cur_adr = '0;      cur_rows = '0;       end
        endcase
        cur_len   = row_len(width_q, cur_plane);
        burst_len = cur_len[8:3];
    end

    always_comb begin
        state_d    = state_q;
        adr_y_d    = adr_y_q;
        adr_u_d    = adr_u_q;
        adr_v_d    = adr_v_q;
        rows_y_d   = rows_y_q;
        rows_u_d   = rows_u_q;
        rows_v_d   = rows_v_q;
        width_d    = width_q;
        byte_cnt_d = byte_cnt_q;
        plane_d    = plane_q;
        pack_d     = pack_q;
        beat_d     = beat_q;
        err_d      = err_q;
        done_d     = 1'b0;
        keep_byte  = 1'b0;
        buf_we     = 1'b0;
        buf_re     = 1'b0;
        buf_raddr  = '0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    adr_y_d    = frame.y_adr;
                    adr_u_d    = frame.u_adr;
                    adr_v_d    = frame.v_adr;
                    rows_y_d   = frame_height;
                    rows_u_d   = {1'b0, frame_height[8:1]};
                    rows_v_d   = {1'b0, frame_height[8:1]};
                    width_d    = frame_width;
                    byte_cnt_d = '0;
                    if (frame_height == '0) done_d  = 1'b1;
                    else                    state_d = StFill;
                end
            end
            StFill: begin
                if (in_valid) begin
                    if (cur_rows == '0) begin
                        err_d = 1'b1;
                    end else begin
                        keep_byte = 1'b1;
                        plane_d   = cur_plane;
                        pack_d[{byte_cnt_q[2:0], 3'b000} +: 8] = in_data;
                        buf_we = (byte_cnt_q[2:0] == 3'd7);
                        if (byte_cnt_q == cur_len - 9'd1) begin
                            byte_cnt_d = '0;
                            state_d    = StFlush;
                        end else begin
                            byte_cnt_d = byte_cnt_q + 9'd1;
                        end
                    end
                end
            end
            StFlush: begin
                buf_re  = 1'b1;
                beat_d  = '0;
                state_d = StBurst;
            end
            StBurst: begin
                if (!ddrif.busy) begin
                    if (beat_q == burst_len - 6'd1) begin
                        case (plane_q)
                            PLANE_Y: begin
                                adr_y_d = adr_y_q + 29'(cur_len); rows_y_d = rows_y_q - 9'd1;
                            end
                            PLANE_U: begin
                                adr_u_d = adr_u_q + 29'(cur_len); rows_u_d = rows_u_q - 9'd1;
                            end
                            default: begin
                                adr_v_d = adr_v_q + 29'(cur_len); rows_v_d = rows_v_q - 9'd1;
                            end
                        endcase
                        if (rows_y_d == '0 && rows_u_d == '0 && rows_v_d == '0) begin
                            done_d  = 1'b1;
                            state_d = StIdle;
                        end else begin
                            state_d = StFill;
                        end
                    end else begin
                        beat_d    = beat_q + 6'd1;
                        buf_re    = 1'b1;
                        buf_raddr = Aw'(beat_q) + Aw'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clkddr) begin
        if (reset) begin
            state_q    <= StIdle;
            adr_y_q    <= '0;
            adr_u_q    <= '0;
            adr_v_q    <= '0;
            rows_y_q   <= '0;
            rows_u_q   <= '0;
            rows_v_q   <= '0;
            width_q    <= '0;
            byte_cnt_q <= '0;
            plane_q    <= PLANE_Y;
            pack_q     <= '0;
            beat_q     <= '0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            adr_y_q    <= adr_y_d;
            adr_u_q    <= adr_u_d;
            adr_v_q    <= adr_v_d;
            rows_y_q   <= rows_y_d;
            rows_u_q   <= rows_u_d;
            rows_v_q   <= rows_v_d;
            width_q    <= width_d;
            byte_cnt_q <= byte_cnt_d;
            plane_q    <= plane_d;
            pack_q     <= pack_d;
            beat_q     <= beat_d;
            err_q      <= err_d;
            done_q     <= done_d;
        end
    end

    ddr_row_buffer #(
        .Words (LINE_WORDS),
        .Aw    (Aw)
    ) u_row_buffer (
        .clkddr  (clkddr),
        .reset   (reset),
        .we_i    (buf_we),
        .waddr_i (Aw'(byte_cnt_q[8:3])),
        .wdata_i (pack_d),
        .re_i    (buf_re),
        .raddr_i (buf_raddr),
        .rdata_o (rdata)
    );

`ifdef FRAME_WRITER_CHECKSUM_EN
    logic [31:0] sum_q;
    always_ff @(posedge clkddr) begin
        if (reset)                          sum_q <= '0;
        else if (start && state_q == StIdle) sum_q <= '0;
        else if (keep_byte)                 sum_q <= sum_q + 32'(in_data);
    end
    assign checksum = sum_q;
`else
    assign checksum = '0;
`endif

    assign in_ready         = (state_q == StFill);
    assign busy             = (state_q != StIdle);
    assign done             = done_q;
    assign ddrif.write      = (state_q == StBurst);
    assign ddrif.acquire    = (state_q == StBurst);
    assign ddrif.read       = 1'b0;
    assign ddrif.byteenable = 8'hff;
    assign ddrif.addr       = (state_q == StBurst) ? {DDR_CORE_BASE, cur_adr[27:3]} : '0;
    assign ddrif.burstcnt   = (state_q == StBurst) ? {2'b00, burst_len} : '0;
    assign ddrif.wdata      = (state_q == StBurst) ? rdata : '0;

    // Address bits outside the DDR window and the sticky error are debug-only.
    logic unused_bits;
    assign unused_bits = ^{cur_adr[28], cur_adr[2:0], err_q, keep_byte};
endmodule

// File: tb/tb_planar_frame_writer.sv
// Directed bench for planar_frame_writer: small frame, stalled DDR, wide frame, reset, empty frame.
module tb_planar_frame_writer;
    import planar_frame_writer_pkg::*;

    logic        clkddr = 1'b0;
    logic        reset  = 1'b1;
    planar_yuv_s frame;
    logic [8:0]  frame_width, frame_height;
    logic        start, in_valid, in_ready, busy, done;
    logic [7:0]  in_data;
    logic [1:0]  in_plane;
    logic [31:0] checksum;

    always #5 clkddr = ~clkddr;

    ddr_if ddr ();

    planar_frame_writer #(.LINE_WORDS(64)) dut (
        .clkddr       (clkddr),
        .reset        (reset),
        .ddrif        (ddr),
        .frame        (frame),
        .frame_width  (frame_width),
        .frame_height (frame_height),
        .start        (start),
        .in_data      (in_data),
        .in_plane     (in_plane),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .busy         (busy),
        .done         (done),
        .checksum     (checksum)
    );

`ifdef FRAME_WRITER_CHECKSUM_EN
    localparam logic [31:0] SmallSum = 32'h0000_0BA8;
`else
    localparam logic [31:0] SmallSum = 32'h0;
`endif

    // 16x2 frame: Y rows at 0x100000/0x100010, U at 0x200000, V at 0x300000.
    logic [28:0] exp_addr [6] = '{29'h0602_0000, 29'h0602_0000, 29'h0602_0002,
                                  29'h0602_0002, 29'h0604_0000, 29'h0606_0000};
    logic [63:0] exp_data [6] = '{64'h0706_0504_0302_0100, 64'h0F0E_0D0C_0B0A_0908,
                                  64'h0706_0504_0302_0100, 64'h0F0E_0D0C_0B0A_0908,
                                  64'hA7A6_A5A4_A3A2_A1A0, 64'hB7B6_B5B4_B3B2_B1B0};
    logic [7:0]  exp_cnt  [6] = '{8'd2, 8'd2, 8'd2, 8'd2, 8'd1, 8'd1};

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // DDR arbiter model: optional 3-cycle stall per beat, beat/burst logging, stability watch.
    logic        stall_en = 1'b0;
    int          stall_cnt = 0, done_cnt = 0, unstable_n = 0;
    logic        ready_seen = 1'b0;
    logic        prev_write = 1'b0, prev_busy = 1'b0;
    logic [28:0] prev_addr;
    logic [63:0] prev_data;
    logic [28:0] q_addr [$];
    logic [63:0] q_data [$];
    logic [7:0]  q_cnt  [$];
    logic [28:0] b_addr [$];
    logic [7:0]  b_cnt  [$];

    always @(negedge clkddr) begin
        if (done) done_cnt++;
        if (in_ready) ready_seen = 1'b1;
        if (stall_en && ddr.write && stall_cnt < 3) begin
            ddr.busy = 1'b1;
            stall_cnt++;
        end else begin
            ddr.busy  = 1'b0;
            stall_cnt = 0;
        end
        if (ddr.write && !prev_write) begin
            b_addr.push_back(ddr.addr);
            b_cnt.push_back(ddr.burstcnt);
        end
        if (ddr.write && prev_write && prev_busy &&
            (ddr.addr !== prev_addr || ddr.wdata !== prev_data)) unstable_n++;
        if (ddr.write && !ddr.busy) begin
            q_addr.push_back(ddr.addr);
            q_data.push_back(ddr.wdata);
            q_cnt.push_back(ddr.burstcnt);
        end
        prev_write = ddr.write;
        prev_busy  = ddr.busy;
        prev_addr  = ddr.addr;
        prev_data  = ddr.wdata;
    end

    task automatic clear_logs();
        q_addr.delete(); q_data.delete(); q_cnt.delete();
        b_addr.delete(); b_cnt.delete();
        done_cnt = 0; unstable_n = 0;
    endtask

    task automatic do_start(input logic [28:0] y, input logic [28:0] u, input logic [28:0] v,
                            input logic [8:0] w, input logic [8:0] h);
        frame.y_adr = y; frame.u_adr = u; frame.v_adr = v;
        frame_width = w; frame_height = h;
        start = 1'b1;
        @(negedge clkddr);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [1:0] p, input logic [7:0] d);
        int n = 0;
        in_valid = 1'b1; in_plane = p; in_data = d;
        while (!in_ready && n < 2000) begin
            @(negedge clkddr);
            n++;
        end
        check("in_ready_wait", in_ready, 1'b1);
        @(negedge clkddr);
        in_valid = 1'b0;
    endtask

    task automatic send_row(input logic [1:0] p, input logic [7:0] first, input int len);
        for (int i = 0; i < len; i++) send_byte(p, first + 8'(i));
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 5000) begin
            @(negedge clkddr);
            n++;
        end
        check(tag, done, 1'b1);
    endtask

    task automatic wait_write(input string tag);
        int n = 0;
        while (!ddr.write && n < 200) begin
            @(negedge clkddr);
            n++;
        end
        check(tag, ddr.write, 1'b1);
    endtask

    task automatic run_small(input string tag);
        clear_logs();
        do_start(29'h10_0000, 29'h20_0000, 29'h30_0000, 9'd16, 9'd2);
        check({tag, "_busy_rise"}, busy, 1'b1);
        send_row(2'd0, 8'h00, 16);
        send_row(2'd0, 8'h00, 16);
        send_row(2'd1, 8'hA0, 8);
        send_row(2'd2, 8'hB0, 8);
        wait_done({tag, "_done"});
        check({tag, "_checksum"}, checksum, SmallSum);
        check({tag, "_busy_fall"}, busy, 1'b0);
        repeat (4) @(negedge clkddr);
        check({tag, "_done_cnt"}, done_cnt, 1);
        check({tag, "_beats"}, q_addr.size(), 6);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("%s_addr%0d", tag, i), q_addr[i], exp_addr[i]);
            check($sformatf("%s_data%0d", tag, i), q_data[i], exp_data[i]);
            check($sformatf("%s_cnt%0d", tag, i), q_cnt[i], exp_cnt[i]);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        in_valid = 1'b0; in_data = '0; in_plane = '0; start = 1'b0;
        frame = '0; frame_width = '0; frame_height = '0;
        repeat (3) @(negedge clkddr);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_write", ddr.write, 1'b0);
        check("rst_acquire", ddr.acquire, 1'b0);
        check("rst_burstcnt", ddr.burstcnt, 8'd0);
        check("rst_addr", ddr.addr, 29'd0);
        check("rst_wdata", ddr.wdata, 64'd0);
        check("rst_checksum", checksum, 32'd0);
        reset = 1'b0;
        @(negedge clkddr);

        run_small("small");

        stall_en = 1'b1;
        run_small("stall");
        check("stall_stable", unstable_n, 0);
        stall_en = 1'b0;

        // 352x8, rows in Y,Y,U,V order.
        clear_logs();
        do_start(29'h1_0000, 29'h4_0000, 29'h6_0000, 9'd352, 9'd8);
        for (int r = 0; r < 4; r++) begin
            send_row(2'd0, 8'h00, 352);
            send_row(2'd0, 8'h00, 352);
            send_row(2'd1, 8'h00, 176);
            send_row(2'd2, 8'h00, 176);
        end
        wait_done("wide_done");
        check("wide_bursts", b_addr.size(), 16);
        check("wide_beats", q_addr.size(), 528);
        check("wide_y1_addr", b_addr[1], 29'h0600_202C);
        check("wide_ylast_addr", b_addr[13], 29'h0600_2134);
        check("wide_ulast_addr", b_addr[14], 29'h0600_8042);
        check("wide_vlast_addr", b_addr[15], 29'h0600_C042);
        check("wide_y_cnt", b_cnt[13], 8'd44);
        check("wide_u_cnt", b_cnt[14], 8'd22);
        check("wide_data0", q_data[0], 64'h0706_0504_0302_0100);

        // Reset on the second beat of a 44-beat burst.
        clear_logs();
        do_start(29'h1_0000, 29'h4_0000, 29'h6_0000, 9'd352, 9'd2);
        send_row(2'd0, 8'h00, 352);
        wait_write("rst_burst_start");
        @(negedge clkddr);
        reset = 1'b1;
        @(negedge clkddr);
        check("rst_mid_write", ddr.write, 1'b0);
        check("rst_mid_acquire", ddr.acquire, 1'b0);
        reset = 1'b0;
        @(negedge clkddr);
        do_start(29'h5_0000, 29'h4_0000, 29'h6_0000, 9'd352, 9'd2);
        send_row(2'd0, 8'h00, 352);
        wait_write("rst_new_burst");
        check("rst_new_addr", ddr.addr, 29'h0600_A000);
        reset = 1'b1;
        repeat (2) @(negedge clkddr);
        reset = 1'b0;
        @(negedge clkddr);

        // Empty frame.
        clear_logs();
        ready_seen = 1'b0;
        do_start(29'h1_0000, 29'h4_0000, 29'h6_0000, 9'd352, 9'd0);
        check("h0_done", done, 1'b1);
        @(negedge clkddr);
        check("h0_done_pulse", done, 1'b0);
        repeat (5) @(negedge clkddr);
        check("h0_ready", ready_seen, 1'b0);
        check("h0_done_cnt", done_cnt, 1);
        check("h0_no_traffic", b_addr.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
